// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared types for the fetch/data memory arbiter: arbiter
//                state encoding, transaction owner encoding and the default
//                data-streak limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Default number of back-to-back data grants tolerated while fetch waits
    localparam int MAX_D_STREAK_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/mem_arb_perf.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_perf
//  Description : Saturating 32-bit event counters for the memory arbiter:
//                fetch-stall cycles, data-stall cycles and arbitration
//                conflicts. Only instantiated when MEM_ARB_PERF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_perf (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_f_i,
    input  logic        stall_m_i,
    input  logic        conflict_i,
    output logic [31:0] perf_f_stall_o,
    output logic [31:0] perf_m_stall_o,
    output logic [31:0] perf_conflict_o
);

    logic [31:0] f_cnt_q;
    logic [31:0] m_cnt_q;
    logic [31:0] c_cnt_q;

    // Count each event once per cycle, sticking at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f_cnt_q <= '0;
            m_cnt_q <= '0;
            c_cnt_q <= '0;
        end else begin
            if (stall_f_i  && (f_cnt_q != '1)) f_cnt_q <= f_cnt_q + 32'd1;
            if (stall_m_i  && (m_cnt_q != '1)) m_cnt_q <= m_cnt_q + 32'd1;
            if (conflict_i && (c_cnt_q != '1)) c_cnt_q <= c_cnt_q + 32'd1;
        end
    end

    assign perf_f_stall_o  = f_cnt_q;
    assign perf_m_stall_o  = m_cnt_q;
    assign perf_conflict_o = c_cnt_q;

endmodule : mem_arb_perf
`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb
//  Description : Arbitrates an instruction-fetch port and a load/store port
//                onto a single memory request channel, one transaction in
//                flight. Data has priority, but fetch is forced through once
//                MAX_D_STREAK data grants have happened while fetch waited.
//                Optional performance counters: define MEM_ARB_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arb
    import riscv_pkg::*;
#(
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    // fetch port
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    // data port
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    // shared memory channel
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    // hazard unit
    output logic        stall_f,
    output logic        stall_m
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_f_stall,
    output logic [31:0] perf_m_stall,
    output logic [31:0] perf_conflict
`endif
);

    localparam int unsigned    SW         = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_D_STREAK);

    arb_state_e     state_q;
    owner_e         owner_q;
    logic [SW-1:0]  d_streak_q;
    logic [SW-1:0]  d_streak_d;
    logic           m_req_q;
    logic           m_we_q;
    logic [3:0]     m_be_q;
    logic [31:0]    m_addr_q;
    logic [31:0]    m_wdata_q;

    logic           w_any_req;
    logic           w_fetch_win;
    logic           w_rsp;

    assign w_any_req   = if_req | d_req;
    // Fetch wins when data is absent, or when data has used up its streak
    assign w_fetch_win = if_req & (~d_req | (d_streak_q == STREAK_MAX));

    // Streak bookkeeping: only changes on an IDLE-cycle grant
    always_comb begin
        d_streak_d = d_streak_q;
        if ((state_q == IDLE) && w_any_req) begin
            if (w_fetch_win || !if_req) begin
                d_streak_d = '0;
            end else if (d_streak_q != STREAK_MAX) begin
                d_streak_d = d_streak_q + SW'(1);
            end
        end
    end

    // Arbiter FSM: latch winner in IDLE, present in ISSUE, await completion in WAIT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= OWN_F;
            d_streak_q <= '0;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_be_q     <= 4'h0;
            m_addr_q   <= 32'h0;
            m_wdata_q  <= 32'h0;
        end else begin
            d_streak_q <= d_streak_d;
            case (state_q)
                IDLE: begin
                    if (w_any_req) begin
                        state_q <= ISSUE;
                        m_req_q <= 1'b1;
                        if (w_fetch_win) begin
                            owner_q   <= OWN_F;
                            m_we_q    <= 1'b0;
                            m_be_q    <= 4'hF;
                            m_addr_q  <= if_addr;
                            m_wdata_q <= 32'h0;
                        end else begin
                            owner_q   <= OWN_D;
                            m_we_q    <= d_we;
                            m_be_q    <= d_be;
                            m_addr_q  <= d_addr;
                            m_wdata_q <= d_wdata;
                        end
                    end
                end
                ISSUE: begin
                    if (m_ready) begin
                        state_q <= WAIT;
                        m_req_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (m_rvalid) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    m_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Completion is same-cycle with m_rvalid; a pending reset suppresses it
    assign w_rsp    = rst_n & (state_q == WAIT) & m_rvalid;
    assign if_valid = w_rsp & (owner_q == OWN_F);
    assign d_valid  = w_rsp & (owner_q == OWN_D);
    // Stores return no data, so d_rdata stays zero for them
    assign if_rdata = if_valid ? m_rdata : 32'h0;
    assign d_rdata  = (d_valid && !m_we_q) ? m_rdata : 32'h0;

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_be     = m_be_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;

    assign stall_f  = if_req & ~if_valid;
    assign stall_m  = d_req & ~d_valid;

`ifdef MEM_ARB_PERF_EN
    logic w_conflict;
    assign w_conflict = (state_q == IDLE) & if_req & d_req;

    mem_arb_perf u_perf (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_f_i       (stall_f),
        .stall_m_i       (stall_m),
        .conflict_i      (w_conflict),
        .perf_f_stall_o  (perf_f_stall),
        .perf_m_stall_o  (perf_m_stall),
        .perf_conflict_o (perf_conflict)
    );
`endif

endmodule : mem_arb
`default_nettype wire

// File: tb/tb_mem_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arb
//  Description : Self-checking bench for mem_arb. The bench plays both
//                requesters and the memory, and predicts every cycle from a
//                transaction-level model of the arbitration rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arb;

    localparam int MAXS = 4;
    localparam int PH_FREE  = 0;
    localparam int PH_ISSUE = 1;
    localparam int PH_WAIT  = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        stall_f;
    logic        stall_m;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_f_stall;
    logic [31:0] perf_m_stall;
    logic [31:0] perf_conflict;
`endif

    always #5 clk = ~clk;

    mem_arb #(.MAX_D_STREAK(MAXS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_valid (if_valid),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_be     (d_be),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_valid  (d_valid),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_be     (m_be),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_ready  (m_ready),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata),
        .stall_f  (stall_f),
        .stall_m  (stall_m)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_f_stall  (perf_f_stall),
        .perf_m_stall  (perf_m_stall),
        .perf_conflict (perf_conflict)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // stimulus controls
    bit          auto_req, keep_if, keep_d, noise_en, fix_rdata_en;
    int          fix_rdy, fix_rv;
    logic [31:0] fix_rdata;
    bit          want_if, want_d, want_we;
    logic [31:0] want_if_addr, want_addr, want_wdata;
    logic [3:0]  want_be;
    bit          last_ifv, last_dv;
    int          mem_st, mem_cnt;
    int          cyc, if_req_cyc, ifv_cyc, dv_cnt;
    bit          obs_q[$];

    // reference model
    int          md_phase, md_streak;
    bit          md_own_f, md_first, md_we;
    logic [3:0]  md_be;
    logic [31:0] md_addr, md_wdata;
    int          exp_pf, exp_pm, exp_pc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset(input int n, input bit rv_pulse);
        @(posedge clk); #1;
        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; m_ready = 1'b0; m_rvalid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1; m_rvalid = rv_pulse; m_rdata = 32'hA5A5_5A5A;
        want_if = 0; want_d = 0; last_ifv = 0; last_dv = 0; mem_st = 0;
        md_phase = PH_FREE; md_streak = 0;
        exp_pf = 0; exp_pm = 0; exp_pc = 0;
        @(negedge clk);
        check_val("rst_m_req",    m_req,    0);
        check_val("rst_m_we",     m_we,     0);
        check_val("rst_m_be",     m_be,     0);
        check_val("rst_m_addr",   m_addr,   0);
        check_val("rst_m_wdata",  m_wdata,  0);
        check_val("rst_if_valid", if_valid, 0);
        check_val("rst_d_valid",  d_valid,  0);
        check_val("rst_if_rdata", if_rdata, 0);
        check_val("rst_d_rdata",  d_rdata,  0);
        check_val("rst_streak",   32'(dut.d_streak_q), 0);
`ifdef MEM_ARB_PERF_EN
        check_val("rst_perf_f", perf_f_stall, 0);
        check_val("rst_perf_m", perf_m_stall, 0);
        check_val("rst_perf_c", perf_conflict, 0);
`endif
    endtask

    task automatic cycle();
        bit          eifv, edv, win_f;
        int          nxt;
        @(posedge clk); #1;
        cyc++;
        // requesters: release after completion, then maybe issue a new request
        if (last_ifv) if_req = 1'b0;
        if (last_dv)  d_req  = 1'b0;
        if (!if_req) begin
            if (want_if) begin
                if_req = 1'b1; if_addr = want_if_addr; want_if = 0; if_req_cyc = cyc;
            end else if (keep_if || (auto_req && $urandom_range(0, 99) < 30)) begin
                if_req = 1'b1; if_addr = $urandom() & 32'hFFFF_FFFC; if_req_cyc = cyc;
            end
        end
        if (!d_req) begin
            if (want_d) begin
                d_req = 1'b1; d_we = want_we; d_be = want_be; d_addr = want_addr;
                d_wdata = want_wdata; want_d = 0;
            end else if (keep_d || (auto_req && $urandom_range(0, 99) < 30)) begin
                d_req = 1'b1; d_we = keep_d ? 1'b1 : 1'($urandom_range(0, 1));
                d_be = 4'($urandom_range(0, 15)); d_addr = $urandom() & 32'hFFFF_FFFC;
                d_wdata = $urandom();
            end
        end
        // memory: accept after a delay, then respond after another delay
        m_ready = 1'b0; m_rvalid = 1'b0;
        m_rdata = fix_rdata_en ? fix_rdata : $urandom();
        if (mem_st == 0 && m_req) begin
            mem_st = 1; mem_cnt = (fix_rdy >= 0) ? fix_rdy : $urandom_range(0, 3);
        end
        if (mem_st == 1) begin
            if (mem_cnt == 0) begin
                m_ready = 1'b1; mem_st = 2;
                mem_cnt = (fix_rv >= 0) ? fix_rv : $urandom_range(0, 3);
            end else mem_cnt--;
        end else if (mem_st == 2) begin
            if (mem_cnt == 0) begin m_rvalid = 1'b1; mem_st = 0; end
            else mem_cnt--;
        end
        // spurious completions outside the wait window must be ignored
        if (noise_en && mem_st != 2 && !m_rvalid && $urandom_range(0, 7) == 0) m_rvalid = 1'b1;

        @(negedge clk);
        eifv = 0; edv = 0; nxt = md_phase;
`ifdef MEM_ARB_PERF_EN
        check_val("perf_f", perf_f_stall, exp_pf);
        check_val("perf_m", perf_m_stall, exp_pm);
        check_val("perf_c", perf_conflict, exp_pc);
`endif
        case (md_phase)
            PH_FREE: begin
                check_val("m_req_idle", m_req, 0);
                if (if_req || d_req) begin
                    if (if_req && d_req) exp_pc++;
                    win_f = if_req && (!d_req || md_streak == MAXS);
                    md_own_f = win_f;
                    if (win_f) begin
                        md_we = 0; md_addr = if_addr; md_streak = 0;
                    end else begin
                        md_we = d_we; md_be = d_be; md_addr = d_addr; md_wdata = d_wdata;
                        md_streak = if_req ? ((md_streak < MAXS) ? md_streak + 1 : MAXS) : 0;
                    end
                    md_first = 1; nxt = PH_ISSUE;
                end
            end
            PH_ISSUE: begin
                check_val("m_req_issue", m_req, 1);
                check_val("m_addr", m_addr, md_addr);
                check_val("m_we", m_we, md_we);
                if (!md_own_f) begin
                    check_val("m_be", m_be, md_be);
                    check_val("m_wdata", m_wdata, md_wdata);
                end
                if (md_first) obs_q.push_back(m_we);
                md_first = 0;
                if (m_ready) nxt = PH_WAIT;
            end
            default: begin
                check_val("m_req_wait", m_req, 0);
                if (m_rvalid) begin
                    if (md_own_f) eifv = 1; else edv = 1;
                    nxt = PH_FREE;
                end
            end
        endcase
        check_val("if_valid", if_valid, eifv);
        check_val("d_valid",  d_valid,  edv);
        check_val("if_rdata", if_rdata, eifv ? m_rdata : 32'h0);
        check_val("d_rdata",  d_rdata,  (edv && !md_we) ? m_rdata : 32'h0);
        check_val("stall_f",  stall_f,  if_req && !eifv);
        check_val("stall_m",  stall_m,  d_req && !edv);
        if (if_req && !eifv) exp_pf++;
        if (d_req && !edv)   exp_pm++;
        if (if_valid) ifv_cyc = cyc;
        if (d_valid)  dv_cnt++;
        last_ifv = if_valid; last_dv = d_valid;
        md_phase = nxt;
    endtask

    initial begin
        int dv0;
        int i;
        rst_n = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0;
        d_addr = 0; d_wdata = 0; m_ready = 0; m_rvalid = 0; m_rdata = 0;
        auto_req = 0; keep_if = 0; keep_d = 0; noise_en = 0; fix_rdata_en = 0;
        fix_rdy = -1; fix_rv = -1; fix_rdata = 0; cyc = 0; ifv_cyc = -100; dv_cnt = 0;
        do_reset(2, 1'b0);

        // fetch-only transaction with minimum latency
        fix_rdy = 0; fix_rv = 0; fix_rdata_en = 1; fix_rdata = 32'h0050_0093;
        want_if = 1; want_if_addr = 32'h0000_0100;
        repeat (5) cycle();
        check_val("fetch_latency", 32'(ifv_cyc - if_req_cyc + 1), 3);

        // store with a slow accept: fields must hold, d_rdata stays zero
        fix_rdy = 3; fix_rv = 1; fix_rdata = 32'h1234_5678; dv0 = dv_cnt;
        want_d = 1; want_we = 1; want_be = 4'b0011; want_addr = 32'h200; want_wdata = 32'hDEAD_BEEF;
        repeat (10) cycle();
        check_val("store_done", 32'(dv_cnt - dv0), 1);

        // both requesters always busy: data wins MAXS times, then fetch once
        do_reset(1, 1'b0);
        fix_rdy = 0; fix_rv = 0; fix_rdata_en = 0; keep_if = 1; keep_d = 1;
        obs_q.delete();
        repeat (40) cycle();
        keep_if = 0; keep_d = 0;
        repeat (8) cycle();
        check_val("grant_count", 32'(obs_q.size() >= 10), 1);
        for (int k = 0; k < 10 && k < obs_q.size(); k++)
            check_val($sformatf("grant_order[%0d]", k), obs_q[k], (k % 5 == 4) ? 1'b0 : 1'b1);

        // reset while a data transaction is waiting, then a stray completion
        fix_rdy = 0; fix_rv = 6;
        want_if = 1; want_if_addr = 32'h400; want_d = 1; want_we = 0; want_be = 4'hF;
        want_addr = 32'h800; want_wdata = 32'h0;
        for (i = 0; i < 10 && md_phase != PH_WAIT; i++) cycle();
        check_val("reached_wait", 32'(md_phase == PH_WAIT), 1);
        check_val("streak_pre_rst", 32'(dut.d_streak_q), md_streak);
        dv0 = dv_cnt;
        do_reset(1, 1'b1);
        repeat (2) cycle();
        check_val("no_valid_after_rst", 32'(dv_cnt - dv0), 0);

        // randomized traffic with random accept/response delays and resets
        fix_rdy = -1; fix_rv = -1; noise_en = 1; auto_req = 1;
        for (int k = 0; k < 3; k++) begin
            repeat (1000) cycle();
            do_reset(1, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mem_arb
`default_nettype wire

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 SHALL have parameter MAX_D_STREAK, default 4, meaning the most consecutive data grants allowed while a fetch request waits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-004 SHALL have port if_req, input, 1, fetch request; held with if_addr stable until if_valid.
REQ-005 SHALL have port if_addr, input, 32, fetch byte address.
REQ-006 SHALL have ports if_rdata (output, 32, instruction word) and if_valid (output, 1, one-cycle completion pulse).
REQ-007 SHALL have ports d_req (input, 1), d_we (input, 1, 1=store), d_be (input, 4, byte enables), d_addr (input, 32) and d_wdata (input, 32); all held stable until d_valid.
REQ-008 SHALL have ports d_rdata (output, 32, load data) and d_valid (output, 1, one-cycle completion pulse for loads and stores).
REQ-009 SHALL have ports m_req, m_we, m_be[3:0], m_addr[31:0] and m_wdata[31:0], all outputs, forming the shared memory request.
REQ-010 SHALL have ports m_ready (input, 1, request accepted), m_rvalid (input, 1, completion) and m_rdata (input, 32).
REQ-011 SHALL have outputs stall_f (1) = if_req & !if_valid and stall_m (1) = d_req & !d_valid, both combinational, to the hazard unit.

Function
REQ-012 SHALL implement states IDLE, ISSUE and WAIT, with one memory transaction outstanding at most.
REQ-013 IDLE: if any request is pending, SHALL register the winner's fields into m_* and its owner, then go to ISSUE; otherwise SHALL stay in IDLE.
REQ-014 Arbitration SHALL grant data over fetch, except that fetch wins when both are pending and d_streak == MAX_D_STREAK.
REQ-015 d_streak SHALL increment, saturating at MAX_D_STREAK, on a data grant while if_req=1.
REQ-016 d_streak SHALL clear on any fetch grant or on any data grant while if_req=0.
REQ-017 ISSUE: m_req SHALL be 1 with the latched fields; the block SHALL go to WAIT on the cycle m_ready=1 and otherwise hold every field unchanged.
REQ-018 WAIT: m_req SHALL be 0; the block SHALL ignore m_rvalid outside WAIT.
REQ-019 On m_rvalid=1 in WAIT, the block SHALL drive the owner's valid for that same cycle, route m_rdata to the owner's rdata, and return to IDLE.
REQ-020 Minimum latency SHALL be 3 cycles from request to valid: arbitrate, issue, complete.
REQ-021 The requester SHALL deassert req or present a new request from the cycle after valid; the new request is arbitrated in the following IDLE cycle.
REQ-022 if_valid and d_valid SHALL never be high in the same cycle.
REQ-023 if_rdata and d_rdata SHALL be 0 whenever their valid is 0.
REQ-024 m_we SHALL be 0 for every fetch transaction.

Reset
REQ-025 With rst_n=0 at a clock edge, the block SHALL go to IDLE, clear d_streak and owner, and set all m_* outputs, valids and rdatas to 0.
REQ-026 A reset during ISSUE or WAIT SHALL abandon the transaction without a valid pulse; the memory SHALL share the same reset.

Configuration
REQ-027 With macro MEM_ARB_PERF_EN defined, the block SHALL add 32-bit saturating outputs perf_f_stall, perf_m_stall and perf_conflict.
REQ-028 perf_f_stall and perf_m_stall SHALL count cycles with stall_f=1 and stall_m=1 respectively.
REQ-029 perf_conflict SHALL count IDLE cycles with both requests pending; all three counters SHALL reset to 0.
REQ-030 Without MEM_ARB_PERF_EN, those ports and their counters SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-031 riscv_pkg SHALL hold the arbiter state enum (IDLE/ISSUE/WAIT), an owner enum (OWN_F/OWN_D) and the MAX_D_STREAK default constant.
REQ-032 The counters SHALL be the sub-module mem_arb_perf, instantiated only under MEM_ARB_PERF_EN.

Verification
REQ-033 Fetch only: if_addr=0x100, m_ready=1 in ISSUE, m_rvalid one cycle later with m_rdata=0x00500093 -> if_valid on cycle 3, if_rdata=0x00500093, m_we=0.
REQ-034 Both requests in the same IDLE cycle -> data granted first; fetch issues in the IDLE cycle after d_valid; perf_conflict increments by 1 when MEM_ARB_PERF_EN is defined.
REQ-035 d_req held continuously with if_req=1 and MAX_D_STREAK=4 -> exactly 4 data grants, then 1 fetch grant, then data again.
REQ-036 Store d_we=1, d_be=4'b0011, d_addr=0x200, d_wdata=0xDEADBEEF, m_ready low for 3 cycles -> m_* fields held stable; d_valid on m_rvalid; d_rdata=0.
REQ-037 rst_n=0 during WAIT, then m_rvalid=1 -> no valid pulse, state IDLE, m_req=0, d_streak=0.
